// File: rtl/uart_rx_frame_sequencer_if.sv
// Interface between the UART receive path and the frame sequencer.
// master: the side that drives ticks, start detection and configuration.
// slave : the sequencer, which returns frame status and sample strobes.
interface uart_rx_frame_sequencer_if #(
  parameter int MAX_DATA_BITS = 9,
  parameter int IDX_W         = $clog2(MAX_DATA_BITS)
) ();
  logic             frame_clear;
  logic             start_detect;
  logic             bit_tick;
  logic [3:0]       cfg_data_bits;
  logic             cfg_parity_en;
  logic             cfg_stop2;
  logic             frame_active;
  logic [IDX_W-1:0] bit_index;
  logic             data_sample_en;
  logic             parity_sample_en;
  logic             stop_sample_en;
  logic             receive_done;
  logic             frame_abort;

  modport master (
    output frame_clear, start_detect, bit_tick, cfg_data_bits, cfg_parity_en, cfg_stop2,
    input  frame_active, bit_index, data_sample_en, parity_sample_en, stop_sample_en,
           receive_done, frame_abort
  );

  modport slave (
    input  frame_clear, start_detect, bit_tick, cfg_data_bits, cfg_parity_en, cfg_stop2,
    output frame_active, bit_index, data_sample_en, parity_sample_en, stop_sample_en,
           receive_done, frame_abort
  );
endinterface

// File: rtl/uart_rx_frame_sequencer.sv
// UART receive frame sequencer: walks start, data, optional parity and
// one or two stop bits from the mid-bit tick, issuing per-field sample
// strobes and a done pulse. Frame format is latched at frame start.
// Optional macro UART_RX_FRAME_TIMEOUT_EN adds an inactivity timeout that
// aborts a frame after TIMEOUT_CYCLES clocks without a bit_tick.
module uart_rx_frame_sequencer #(
  parameter int MAX_DATA_BITS  = 9,
  parameter int IDX_W          = $clog2(MAX_DATA_BITS),
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      pclk,
  input  logic                      presetn,
  uart_rx_frame_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  localparam logic [3:0] MAXB = 4'(MAX_DATA_BITS);

  state_t           r_state;
  logic [IDX_W-1:0] r_bit_index;
  logic [3:0]       r_nbits;
  logic             r_par;
  logic             r_stop2;
  logic             r_stop_cnt;
  logic             r_active;
  logic             r_done;
  logic [3:0]       w_nbits_clamped;
  logic             w_last_data;
  logic             w_timeout;
  logic             w_busy;

  // Clamp the requested data width into the supported range before latching
  always_comb begin
    w_nbits_clamped = bus.cfg_data_bits;
    if (bus.cfg_data_bits < 4'd5)     w_nbits_clamped = 4'd5;
    else if (bus.cfg_data_bits > MAXB) w_nbits_clamped = MAXB;
  end

  assign w_last_data = (r_bit_index == IDX_W'(r_nbits - 4'd1));
  assign w_busy      = (r_state == S_START) || (r_state == S_DATA) ||
                       (r_state == S_PARITY) || (r_state == S_STOP);

`ifdef UART_RX_FRAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_abort;

  // Fires on the edge that would bring the idle-tick count up to TIMEOUT_CYCLES
  assign w_timeout = w_busy && !bus.bit_tick && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Inactivity counter: cleared by any tick and outside an active frame
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)                                      r_to_cnt <= '0;
    else if (bus.frame_clear || !w_busy || bus.bit_tick || w_timeout) r_to_cnt <= '0;
    else                                               r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Registered one-cycle abort pulse
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_abort <= 1'b0;
    else          r_abort <= w_timeout && !bus.frame_clear;
  end

  assign bus.frame_abort = r_abort;
`else
  assign w_timeout       = 1'b0;
  assign bus.frame_abort = 1'b0;
`endif

  // Frame sequencing FSM with registered status outputs
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= S_IDLE;
      r_bit_index <= '0;
      r_nbits     <= 4'd8;
      r_par       <= 1'b0;
      r_stop2     <= 1'b0;
      r_stop_cnt  <= 1'b0;
      r_active    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.frame_clear) begin
        r_state  <= S_IDLE;
        r_active <= 1'b0;
      end else if (w_timeout) begin
        r_state  <= S_IDLE;
        r_active <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (bus.start_detect) begin
            r_state  <= S_START;
            r_nbits  <= w_nbits_clamped;
            r_par    <= bus.cfg_parity_en;
            r_stop2  <= bus.cfg_stop2;
            r_active <= 1'b1;
          end
          S_START: if (bus.bit_tick) begin
            r_state     <= S_DATA;
            r_bit_index <= '0;
          end
          S_DATA: if (bus.bit_tick) begin
            if (w_last_data) begin
              r_state    <= r_par ? S_PARITY : S_STOP;
              r_stop_cnt <= 1'b0;
            end else begin
              r_bit_index <= r_bit_index + 1'b1;
            end
          end
          S_PARITY: if (bus.bit_tick) begin
            r_state    <= S_STOP;
            r_stop_cnt <= 1'b0;
          end
          S_STOP: if (bus.bit_tick) begin
            if (!r_stop2 || r_stop_cnt) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_active <= 1'b0;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Strobes follow the tick in the same cycle so the datapath samples mid-bit
  assign bus.data_sample_en   = bus.bit_tick && (r_state == S_DATA);
  assign bus.parity_sample_en = bus.bit_tick && (r_state == S_PARITY);
  assign bus.stop_sample_en   = bus.bit_tick && (r_state == S_STOP);
  assign bus.frame_active     = r_active;
  assign bus.bit_index        = r_bit_index;
  assign bus.receive_done     = r_done;

endmodule

// File: tb/tb_uart_rx_frame_sequencer.sv
// Bench for uart_rx_frame_sequencer: frame-level model (ticks consumed vs
// frame length) checked every cycle, plus literal per-frame strobe counts.
module tb_uart_rx_frame_sequencer;
  localparam int T = 64;

  logic pclk = 1'b0;
  logic presetn = 1'b0;

  uart_rx_frame_sequencer_if #(.MAX_DATA_BITS(9)) bus ();

  uart_rx_frame_sequencer #(.MAX_DATA_BITS(9), .TIMEOUT_CYCLES(T)) dut (
    .pclk(pclk), .presetn(presetn), .bus(bus)
  );

  always #5 pclk = ~pclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame model ----------------
  // A frame is a list of 1+N+P+S ticks; m_c = ticks already consumed.
  bit m_active, m_done, m_abort;
  int m_c, m_n, m_p, m_s, m_tc;

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      m_active = 0; m_done = 0; m_abort = 0; m_c = 0; m_tc = 0;
      m_n = 8; m_p = 0; m_s = 1;
    end else begin
      bit was_done;
      was_done = m_done;
      m_done = 0; m_abort = 0;
      if (bus.frame_clear) begin
        m_active = 0;
      end else if (was_done) begin
        // DONE cycle: start_detect ignored
      end else if (!m_active) begin
        if (bus.start_detect) begin
          m_active = 1; m_c = 0; m_tc = 0;
          m_n = (bus.cfg_data_bits < 5) ? 5 : (bus.cfg_data_bits > 9) ? 9 : int'(bus.cfg_data_bits);
          m_p = bus.cfg_parity_en ? 1 : 0;
          m_s = bus.cfg_stop2 ? 2 : 1;
        end
      end else if (bus.bit_tick) begin
        m_c++; m_tc = 0;
        if (m_c == 1 + m_n + m_p + m_s) begin m_active = 0; m_done = 1; end
      end else begin
`ifdef UART_RX_FRAME_TIMEOUT_EN
        m_tc++;
        if (m_tc == T) begin m_active = 0; m_abort = 1; m_tc = 0; end
`endif
      end
    end
  end

  // ---------------- per-cycle compare + observed counts ----------------
  int cnt_data = 0, cnt_par = 0, cnt_stop = 0, cnt_done = 0, cnt_abort = 0;
  int last_idx = -1;

  always @(negedge pclk) begin
    bit tk, e_data, e_par, e_stop;
    tk     = bus.bit_tick;
    e_data = m_active && tk && m_c >= 1 && m_c <= m_n;
    e_par  = m_active && tk && m_p == 1 && m_c == m_n + 1;
    e_stop = m_active && tk && m_c >= 1 + m_n + m_p;
    chk("data_sample_en",   bus.data_sample_en,   e_data);
    chk("parity_sample_en", bus.parity_sample_en, e_par);
    chk("stop_sample_en",   bus.stop_sample_en,   e_stop);
    chk("frame_active",     bus.frame_active,     m_active);
    chk("receive_done",     bus.receive_done,     m_done);
    chk("frame_abort",      bus.frame_abort,      m_abort);
    if (e_data) chk("bit_index", bus.bit_index, m_c - 1);
    if (bus.data_sample_en)   begin cnt_data++; last_idx = bus.bit_index; end
    if (bus.parity_sample_en) cnt_par++;
    if (bus.stop_sample_en)   cnt_stop++;
    if (bus.receive_done)     cnt_done++;
    if (bus.frame_abort)      cnt_abort++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      cyc(15);
      bus.bit_tick = 1'b1; cyc(1); bus.bit_tick = 1'b0;
    end
  endtask

  task automatic start();
    bus.start_detect = 1'b1; cyc(1); bus.start_detect = 1'b0;
  endtask

  task automatic cfg(input int n, input bit p, input bit s2);
    bus.cfg_data_bits = 4'(n); bus.cfg_parity_en = p; bus.cfg_stop2 = s2;
  endtask

  int d0, p0, s0, k0;

  task automatic snap();
    d0 = cnt_data; p0 = cnt_par; s0 = cnt_stop; k0 = cnt_done;
  endtask

  task automatic frame_counts(input string tag, input int d, input int p, input int s,
                              input int k, input int li);
    chk({tag, " data strobes"},   cnt_data - d0, d);
    chk({tag, " parity strobes"}, cnt_par - p0,  p);
    chk({tag, " stop strobes"},   cnt_stop - s0, s);
    chk({tag, " done pulses"},    cnt_done - k0, k);
    if (li >= 0) chk({tag, " last bit_index"}, last_idx, li);
  endtask

  initial begin
    bus.frame_clear = 0; bus.start_detect = 0; bus.bit_tick = 0;
    cfg(8, 0, 0);
    #12;
    chk("reset frame_active", bus.frame_active, 0);
    chk("reset receive_done", bus.receive_done, 0);
    chk("reset bit_index",    bus.bit_index,    0);
    chk("reset frame_abort",  bus.frame_abort,  0);
    cyc(3);
    presetn = 1'b1;
    cyc(2);

    // 8N1: 10 ticks
    snap(); start();
    chk("8N1 active after start", bus.frame_active, 1);
    ticks(10);
    chk("8N1 done after tick 10", bus.receive_done, 1);
    chk("8N1 active drops with done", bus.frame_active, 0);
    cyc(2);
    frame_counts("8N1", 8, 0, 1, 1, 7);

    // 5E2: 9 ticks
    cfg(5, 1, 1); snap(); start(); ticks(9); cyc(2);
    frame_counts("5E2", 5, 1, 2, 1, 4);

    // 9E2: 13 ticks
    cfg(9, 1, 1); snap(); start(); ticks(13); cyc(2);
    frame_counts("9E2", 9, 1, 2, 1, 8);

    // mid-frame config change has no effect until the next frame
    cfg(8, 0, 0); snap(); start(); ticks(3);
    cfg(5, 1, 1); ticks(6);
    chk("cfg change not done at 9", bus.receive_done, 0);
    chk("cfg change still active",  bus.frame_active, 1);
    ticks(1);
    chk("cfg change done at 10", bus.receive_done, 1);
    cyc(2);
    frame_counts("cfg change", 8, 0, 1, 1, 7);
    snap(); start(); ticks(9);
    chk("next frame 5E2 done at 9", bus.receive_done, 1);
    cyc(2);
    frame_counts("next frame", 5, 1, 2, 1, 4);

    // frame_clear during DATA at bit_index 4
    cfg(8, 0, 0); start(); ticks(5);
    chk("clear pre bit_index", bus.bit_index, 4);
    bus.frame_clear = 1'b1; cyc(1); bus.frame_clear = 1'b0;
    chk("clear active", bus.frame_active, 0);
    snap(); ticks(5); cyc(2);
    frame_counts("after clear", 0, 0, 0, 0, -1);
    snap(); start(); ticks(10); cyc(2);
    frame_counts("post clear frame", 8, 0, 1, 1, 7);

    // back-to-back, cfg_data_bits=3 clamps to 5 -> 7 ticks
    cfg(3, 0, 0); snap(); start(); ticks(7);
    chk("b2b first done", bus.receive_done, 1);
    start();  // lands in DONE: ignored
    chk("b2b start in DONE ignored", bus.frame_active, 0);
    start();
    chk("b2b next start accepted", bus.frame_active, 1);
    ticks(7);
    chk("b2b second done", bus.receive_done, 1);
    cyc(2);
    frame_counts("b2b", 10, 0, 2, 2, 4);

    // ticks stop after tick 4
    cfg(8, 0, 0); start(); ticks(4);
`ifdef UART_RX_FRAME_TIMEOUT_EN
    cyc(T - 1);
    chk("timeout not yet", bus.frame_abort, 0);
    chk("timeout still active", bus.frame_active, 1);
    cyc(1);
    chk("timeout abort pulse", bus.frame_abort, 1);
    chk("timeout active drop", bus.frame_active, 0);
    chk("timeout no done", bus.receive_done, 0);
    cyc(2);
`else
    cyc(200);
    chk("no timeout active held", bus.frame_active, 1);
    chk("no timeout abort", bus.frame_abort, 0);
    bus.frame_clear = 1'b1; cyc(1); bus.frame_clear = 1'b0;
`endif

    // async reset mid-frame
    start(); ticks(4);
    #2 presetn = 1'b0;
    #1;
    chk("async rst active", bus.frame_active, 0);
    chk("async rst bit_index", bus.bit_index, 0);
    chk("async rst done", bus.receive_done, 0);
    cyc(1); presetn = 1'b1; cyc(1);
    snap(); start(); ticks(10);
    chk("post reset done", bus.receive_done, 1);
    cyc(2);
    frame_counts("post reset", 8, 0, 1, 1, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame_sequencer.md
Name: uart_rx_frame_sequencer

Overview:
Parametrised successor to the fixed 10-bit receive frame counter in the UART receive path. Tracks each received frame bit by bit (start, data, optional parity, stop) from the bit-sample tick supplied by the baud generator. Issues per-field sample strobes for the shift register, parity checker and stop checker. Asserts a done pulse at the end of the frame. Frame format is run-time configurable and is latched at frame start.

Parameters:
MAX_DATA_BITS, 9, largest supported data field; cfg_data_bits is legal from 5 to MAX_DATA_BITS.
IDX_W, $clog2(MAX_DATA_BITS), width of bit_index (derived; do not override).
TIMEOUT_CYCLES, 4096, pclk cycles without bit_tick before an active frame is aborted (used only with the optional feature).

Ports:
pclk  input  1  clock.
presetn  input  1  reset; asynchronous, active-low.
frame_clear  input  1  synchronous abort; returns to IDLE.
start_detect  input  1  falling edge on RX qualified; begins a frame.
bit_tick  input  1  one-cycle strobe at the middle of each bit period.
cfg_data_bits  input  4  number of data bits (5..MAX_DATA_BITS).
cfg_parity_en  input  1  parity bit present.
cfg_stop2  input  1  0 = one stop bit, 1 = two stop bits.
frame_active  output  1  high from accepted start_detect until done or abort.
bit_index  output  IDX_W  current data bit index (0 = LSB).
data_sample_en  output  1  sample the RX line into the data shift register.
parity_sample_en  output  1  sample the parity bit.
stop_sample_en  output  1  sample a stop bit.
receive_done  output  1  one-cycle pulse; frame complete.
frame_abort  output  1  one-cycle pulse; frame aborted by timeout.

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0.
  - Latched config = 8 data bits, no parity, 1 stop bit.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE:
  - start_detect=1 → START.
  - Latch cfg_data_bits, cfg_parity_en and cfg_stop2.
  - frame_active goes to 1 the next cycle.
- START: bit_tick → DATA, with bit_index=0.
  - The start-bit tick produces no strobe. Start-bit validity is checked outside this block.
- DATA:
  - data_sample_en = bit_tick (combinational, same cycle).
  - Each tick increments bit_index.
  - On the tick where bit_index == latched N-1: go to PARITY if parity is enabled, else STOP. bit_index holds at N-1.
- PARITY: parity_sample_en = bit_tick. Tick → STOP.
- STOP:
  - stop_sample_en = bit_tick.
  - Internal stop counter: one tick for cfg_stop2=0, two ticks for cfg_stop2=1.
  - Last stop tick → DONE.
- DONE:
  - receive_done=1 for exactly one cycle, and frame_active drops in the same cycle.
  - Unconditionally → IDLE.
  - A start_detect in DONE is ignored. The next frame can start no earlier than the cycle after DONE.
- Frame length in ticks = 1 + N + P + S. The default 8N1 frame is 10 ticks, matching the legacy counter.
- Priority:
  - presetn, then frame_clear, then timeout abort, then normal sequencing.
  - frame_clear in any state → IDLE next cycle, all strobes deasserted. No receive_done.
- Ignored inputs:
  - start_detect outside IDLE is ignored.
  - bit_tick in IDLE or DONE is ignored.
- Config changes mid-frame have no effect until the next frame start.
- Illegal cfg_data_bits is clamped when latched: below 5 → 5, above MAX_DATA_BITS → MAX_DATA_BITS.
- Sample strobes are combinational from bit_tick and the registered state. receive_done and frame_abort are registered.
- Async reset mid-frame: immediate return to IDLE, all outputs 0.

Optional Feature:
- Macro UART_RX_FRAME_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) resets on every bit_tick and whenever the block is in IDLE.
  - It increments in START, DATA, PARITY and STOP.
  - On reaching TIMEOUT_CYCLES: frame_abort pulses for one cycle and the state returns to IDLE with no receive_done.
- When undefined:
  - No counter is instantiated and frame_abort is tied to 0.
  - An active frame waits for ticks indefinitely.

Test Plan:
- 8N1 (cfg 8/0/0): start_detect, then 10 ticks 16 cycles apart → 8 data_sample_en with bit_index 0..7, 1 stop_sample_en, receive_done 1 cycle after tick 10, frame_active high throughout.
- 5E2 (cfg 5/1/1): 1+5+1+2=9 ticks → 5 data strobes, 1 parity_sample_en, 2 stop strobes, receive_done after tick 9. Repeat with cfg 9/1/1: 13 ticks.
- Config change mid-frame: start with cfg 8/0/0, switch to 5/1/1 after tick 3 → frame still completes after 10 ticks. The next frame uses 5/1/1.
- frame_clear asserted during DATA at bit_index=4 → IDLE next cycle, no receive_done, no strobes on later ticks. A new start_detect then gives a clean 10-tick frame.
- Back-to-back frames: start_detect in the DONE cycle is ignored. start_detect one cycle later starts a frame. cfg_data_bits=3 is latched as 5.
- With UART_RX_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=64: stop ticks after tick 4 → frame_abort exactly 64 cycles after the last tick, then IDLE, no receive_done. Without the macro, frame_active stays high.
